// File: rtl/x_cal_pkg.sv
// Shared types and width helpers for the VDL calibration sweep and its edge encoder.
package x_cal_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_EMIT
   } cal_state_t;

   // Record layout MSB..LSB: setting, sum, then (optionally) max, min.
   localparam int REC_MINMAX_FIELDS = 2;

   function automatic int f_w_idx(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int f_w_pos(input int taps);
      return $clog2(taps + 1);
   endfunction

   function automatic int f_w_sum(input int taps, input int caps);
      return f_w_pos(taps) + $clog2(caps);
   endfunction

   function automatic int f_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/x_edge_enc.sv
// Delay-line edge encoder: lowest tap index whose value differs from tap 0, or P_TAPS when flat.
module x_edge_enc
   import x_cal_pkg::*;
#(
   parameter int P_TAPS = 256,
   localparam int W_P = f_w_pos(P_TAPS)
) (
   input  logic [P_TAPS-1:0] data,
   output logic [W_P-1:0]    pos
);

   always_comb begin
      pos = W_P'(P_TAPS);
      for (int i = P_TAPS - 1; i >= 1; i--) begin
         if (data[i] != data[0]) pos = W_P'(i);
      end
   end

endmodule

// File: rtl/x_cal_sweep.sv
// VDL calibration sweep: step one-hot ctrl, settle, capture/accumulate edges, stream one record per setting.
// Optional min/max edge tracking enabled by defining X_CAL_SWEEP_MINMAX_EN.
module x_cal_sweep
   import x_cal_pkg::*;
#(
   parameter int P_TAPS     = 256,
   parameter int P_SETTINGS = 256,
   parameter int P_CAPS     = 4,
   parameter int P_SETTLE   = 4,
   localparam int W_S   = f_w_idx(P_SETTINGS),
   localparam int W_P   = f_w_pos(P_TAPS),
   localparam int W_SUM = f_w_sum(P_TAPS, P_CAPS),
`ifdef X_CAL_SWEEP_MINMAX_EN
   localparam int W_REC = W_S + W_SUM + REC_MINMAX_FIELDS * W_P
`else
   localparam int W_REC = W_S + W_SUM
`endif
) (
   input  logic                  i_clk,
   input  logic                  i_nrst,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [P_TAPS-1:0]     i_data,
   output logic [P_SETTINGS-1:0] o_ctrl,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [W_REC-1:0]      o_rec,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int W_CNT = f_w_idx(f_max(P_SETTLE, P_CAPS) + 1);

   cal_state_t          state, nxt_state;
   logic [W_CNT-1:0]    cnt;
   logic [W_S-1:0]      setting;
   logic [W_SUM-1:0]    acc;
   logic [P_TAPS-1:0]   data_p0;
   logic                vld_p0;
   logic [W_P-1:0]      edge_pos;
   logic                settle_end, cap_end, cap_take, last;

   assign settle_end = (state == S_SETTLE)  && (cnt == W_CNT'(P_SETTLE - 1));
   assign cap_end    = (state == S_CAPTURE) && (cnt == W_CNT'(P_CAPS));
   assign cap_take   = (state == S_CAPTURE) && (cnt < W_CNT'(P_CAPS));
   assign last       = (setting == W_S'(P_SETTINGS - 1));

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) state <= S_IDLE;
      else         state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      unique case (state)
         S_IDLE:    if (i_start)    nxt_state = S_SETTLE;
         S_SETTLE:  if (settle_end) nxt_state = S_CAPTURE;
         S_CAPTURE: if (cap_end)    nxt_state = S_EMIT;
         S_EMIT:    if (i_ready)    nxt_state = last ? S_IDLE : S_SETTLE;
         default:                   nxt_state = S_IDLE;
      endcase
      if (i_abort) nxt_state = S_IDLE;
   end

   // Stage p0: registered snapshot; its encoded edge accumulates one cycle later (drain cycle covers the last).
   always_ff @(posedge i_clk) begin
      if (cap_take) data_p0 <= i_data;
   end

   x_edge_enc #(.P_TAPS(P_TAPS)) u_enc (
      .data (data_p0),
      .pos  (edge_pos)
   );

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         cnt     <= '0;
         setting <= '0;
         acc     <= '0;
         vld_p0  <= 1'b0;
      end else if (i_abort) begin
         cnt     <= '0;
         setting <= '0;
         vld_p0  <= 1'b0;
      end else begin
         vld_p0 <= cap_take;
         if (vld_p0) acc <= acc + W_SUM'(edge_pos);
         unique case (state)
            S_IDLE: begin
               if (i_start) begin
                  setting <= '0;
                  cnt     <= '0;
               end
            end
            S_SETTLE: begin
               if (settle_end) begin
                  cnt <= '0;
                  acc <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_CAPTURE: cnt <= cap_end ? '0 : cnt + 1'b1;
            S_EMIT: begin
               if (i_ready) begin
                  setting <= last ? '0 : setting + 1'b1;
                  cnt     <= '0;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

`ifdef X_CAL_SWEEP_MINMAX_EN
   logic [W_P-1:0] min_p1, max_p1;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         min_p1 <= W_P'(P_TAPS);
         max_p1 <= '0;
      end else if (!i_abort) begin
         if (settle_end) begin
            min_p1 <= W_P'(P_TAPS);
            max_p1 <= '0;
         end else if (vld_p0) begin
            if (edge_pos < min_p1) min_p1 <= edge_pos;
            if (edge_pos > max_p1) max_p1 <= edge_pos;
         end
      end
   end
`endif

   always_comb begin
      o_busy  = (state != S_IDLE);
      o_valid = (state == S_EMIT);
      o_done  = (state == S_EMIT) && i_ready && last && !i_abort;
      o_ctrl  = P_SETTINGS'(1) << setting;
`ifdef X_CAL_SWEEP_MINMAX_EN
      o_rec   = {setting, acc, max_p1, min_p1};
`else
      o_rec   = {setting, acc};
`endif
   end

endmodule

// File: tb/tb_x_cal_sweep.sv
// Scoreboard bench for x_cal_sweep at 16 taps, 4 settings, 4 captures, settle 2.
module tb_x_cal_sweep;

   localparam int W_S   = 2;
   localparam int W_P   = 5;
   localparam int W_SUM = 7;
`ifdef X_CAL_SWEEP_MINMAX_EN
   localparam int W_REC = W_S + W_SUM + 2 * W_P;
`else
   localparam int W_REC = W_S + W_SUM;
`endif

   logic             clk, i_nrst, i_start, i_abort, i_ready;
   logic [15:0]      i_data;
   logic [3:0]       o_ctrl;
   logic             o_valid, o_busy, o_done;
   logic [W_REC-1:0] o_rec;

   x_cal_sweep #(.P_TAPS(16), .P_SETTINGS(4), .P_CAPS(4), .P_SETTLE(2)) dut (
      .i_clk   (clk),
      .i_nrst  (i_nrst),
      .i_start (i_start),
      .i_abort (i_abort),
      .i_data  (i_data),
      .o_ctrl  (o_ctrl),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_rec   (o_rec),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   typedef struct {
      logic [W_REC-1:0] rec;
      logic [3:0]       ctrl;
      int               gap;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   checks = 0, failures = 0;
   int   cyc = 0, last_hs = 0, done_cnt = 0;

   logic [15:0] vec [4][4] = '{
      '{16'h0001, 16'h0003, 16'h0007, 16'h0000},
      '{16'hFFFE, 16'h8000, 16'hFFFF, 16'h0001},
      '{16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF},
      '{16'h0003, 16'h00FF, 16'h0001, 16'h000F}};
   int edg [4][4] = '{'{1, 2, 3, 16}, '{1, 15, 16, 1}, '{8, 8, 8, 8}, '{2, 8, 1, 4}};
   int flat [4] = '{8, 8, 8, 8};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [W_REC-1:0] mk_rec(input int s, input int e [4]);
      int sum, mn, mx;
      sum = 0; mn = 16; mx = 0;
      for (int k = 0; k < 4; k++) begin
         sum += e[k];
         if (e[k] < mn) mn = e[k];
         if (e[k] > mx) mx = e[k];
      end
`ifdef X_CAL_SWEEP_MINMAX_EN
      return {W_S'(s), W_SUM'(sum), W_P'(mx), W_P'(mn)};
`else
      return {W_S'(s), W_SUM'(sum + 0 * (mn + mx))};
`endif
   endfunction

   task automatic push(input int s, input int e [4], input int gap);
      exp_t x;
      x.rec  = mk_rec(s, e);
      x.ctrl = 4'(1 << s);
      x.gap  = gap;
      sbq.push_back(x);
   endtask

   task automatic push_flat_sweep(input int n);
      for (int s = 0; s < n; s++) push(s, flat, (s == 0) ? 0 : 8);
   endtask

   task automatic start_pulse();
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (o_busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_idle"}, o_busy, 1'b0);
   endtask

   // Monitor: pops and compares on every accepted record, counts done pulses.
   always @(negedge clk) begin
      #2;
      if (i_nrst && o_valid && i_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_record actual=%0h required=none", o_rec);
         end else begin
            mon_e = sbq.pop_front();
            chk("rec", o_rec, mon_e.rec);
            chk("ctrl_at_rec", o_ctrl, mon_e.ctrl);
            if (mon_e.gap != 0) chk("rec_gap", cyc - last_hs, mon_e.gap);
         end
         last_hs = cyc;
      end
      if (i_nrst && o_done) done_cnt++;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      i_nrst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_data = '0; i_ready = 1'b1;
      repeat (3) @(negedge clk);
      i_nrst = 1'b1;
      @(negedge clk);
      chk("rst_ctrl", o_ctrl, 4'b0001);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_done", o_done, 1'b0);
      chk("rst_rec", o_rec, '0);

      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (o_busy || o_valid || o_done || o_ctrl != 4'b0001) bad++;
      end
      chk("idle_quiet", bad, 0);

      // Constant 0x00FF: sum 32 per setting, records 8 cycles apart.
      i_data = 16'h00FF;
      push_flat_sweep(4);
      start_pulse();
      wait_idle("sweep_flat");
      chk("sweep_flat_done", done_cnt, 1);
      chk("sweep_flat_ctrl_back", o_ctrl, 4'b0001);
      chk("sweep_flat_drained", sbq.size(), 0);

      // Per-capture vectors, aligned to each setting's capture window.
      for (int s = 0; s < 4; s++) push(s, edg[s], (s == 0) ? 0 : 8);
      start_pulse();
      repeat (2) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         for (int k = 0; k < 4; k++) begin
            i_data = vec[s][k];
            @(negedge clk);
         end
         repeat (4) @(negedge clk);
      end
      wait_idle("sweep_vec");
      chk("sweep_vec_done", done_cnt, 2);
      chk("sweep_vec_drained", sbq.size(), 0);

      // Backpressure in EMIT of setting 0.
      i_data  = 16'h00FF;
      i_ready = 1'b0;
      push_flat_sweep(4);
      start_pulse();
      bad = 0;
      while (!o_valid && bad < 100) begin
         @(negedge clk);
         bad++;
      end
      chk("bp_reach_emit", o_valid, 1'b1);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!o_valid || o_rec !== mk_rec(0, flat) || o_ctrl !== 4'b0001) bad++;
      end
      chk("bp_stable", bad, 0);
      i_ready = 1'b1;
      wait_idle("bp");
      chk("bp_done", done_cnt, 3);
      chk("bp_drained", sbq.size(), 0);

      // Abort during capture of setting 2.
      push_flat_sweep(2);
      start_pulse();
      repeat (19) @(negedge clk);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      chk("abort_busy", o_busy, 1'b0);
      chk("abort_valid", o_valid, 1'b0);
      chk("abort_ctrl", o_ctrl, 4'b0001);
      repeat (10) @(negedge clk);
      chk("abort_no_done", done_cnt, 3);
      chk("abort_drained", sbq.size(), 0);

      i_start = 1'b1; i_abort = 1'b1;
      @(negedge clk);
      i_start = 1'b0; i_abort = 1'b0;
      chk("start_abort_idle", o_busy, 1'b0);

      // Restart from setting 0; a start pulse mid-sweep must be ignored.
      push_flat_sweep(4);
      start_pulse();
      repeat (13) @(negedge clk);
      start_pulse();
      wait_idle("restart");
      chk("restart_done", done_cnt, 4);
      chk("restart_drained", sbq.size(), 0);

      // Asynchronous reset in the middle of setting 1.
      push_flat_sweep(1);
      start_pulse();
      repeat (12) @(negedge clk);
      #2 i_nrst = 1'b0;
      #1;
      chk("arst_busy", o_busy, 1'b0);
      chk("arst_ctrl", o_ctrl, 4'b0001);
      chk("arst_valid", o_valid, 1'b0);
      chk("arst_rec", o_rec, '0);
      @(negedge clk);
      i_nrst = 1'b1;
      repeat (3) @(negedge clk);
      chk("arst_stays_idle", o_busy, 1'b0);
      chk("final_drained", sbq.size(), 0);
      chk("final_done", done_cnt, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
